// File: rtl/mux_syn_src.sv
// Source side of a mux synchronizer: registers a word and
// holds wr_req high for REQ_HIGH cycles, then low for GAP_CYCLES.
//
// Ports:
//   wr_clk      sole clock, rising edge
//   wr_reset    async active-high reset
//   in_valid    upstream word available
//   in_data     upstream word
//   in_ready    block can accept a word (state == IDLE)
//   wr_data     registered word to the synchronizer
//   wr_req      registered request level to the synchronizer
//   busy        high whenever not IDLE
//   sent_count  words accepted since reset (wraps at 2^16)
module mux_syn_src #(
  parameter int DATA_WIDTH = 12,
  parameter int REQ_HIGH   = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_req,
  output logic                  busy,
  output logic [15:0]           sent_count
);

  localparam int MAXC =
    (REQ_HIGH > GAP_CYCLES) ? REQ_HIGH : GAP_CYCLES;
  localparam int CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] REQ_LOAD = CW'(REQ_HIGH - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    wr_req_q, wr_req_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [15:0]             sent_q, sent_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_req_d  = wr_req_q;
    wr_data_d = wr_data_q;
    sent_d    = sent_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_data_d = in_data;
          wr_req_d  = 1'b1;
          state_d   = REQ;
          cnt_d     = REQ_LOAD;
          sent_d    = sent_q + 16'd1;
        end
      end
      REQ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          wr_req_d = 1'b0;
          state_d  = GAP;
          cnt_d    = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      sent_q    <= sent_d;
    end
  end

  // in_ready and busy depend on the state register only
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign wr_req     = wr_req_q;
  assign wr_data    = wr_data_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_mux_syn_src.sv
// Bench for mux_syn_src: default params plus a
// REQ_HIGH=1/GAP_CYCLES=1 instance.
module tb_mux_syn_src;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v   = 1'b0;
  logic [11:0] d   = '0;
  logic        rdy, req, bsy;
  logic [11:0] wd;
  logic [15:0] cnt;

  logic        v2 = 1'b0;
  logic [11:0] d2 = '0;
  logic        rdy2, req2, bsy2;
  logic [11:0] wd2;
  logic [15:0] cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_syn_src #(
    .DATA_WIDTH (12),
    .REQ_HIGH   (3),
    .GAP_CYCLES (4)
  ) dut (
    .wr_clk     (clk),
    .wr_reset   (rst),
    .in_valid   (v),
    .in_data    (d),
    .in_ready   (rdy),
    .wr_data    (wd),
    .wr_req     (req),
    .busy       (bsy),
    .sent_count (cnt)
  );

  mux_syn_src #(
    .DATA_WIDTH (12),
    .REQ_HIGH   (1),
    .GAP_CYCLES (1)
  ) dut2 (
    .wr_clk     (clk),
    .wr_reset   (rst),
    .in_valid   (v2),
    .in_data    (d2),
    .in_ready   (rdy2),
    .wr_data    (wd2),
    .wr_req     (req2),
    .busy       (bsy2),
    .sent_count (cnt2)
  );

  typedef struct {
    logic        v;
    logic [11:0] d;
    logic        rdy;
    logic        req;
    logic [11:0] wd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic e_rdy,
                         input logic e_req,
                         input logic [11:0] e_wd,
                         input logic [15:0] e_cnt);
    chk({nm, ".ready"}, 32'(rdy), 32'(e_rdy));
    chk({nm, ".busy"},  32'(bsy), 32'(!e_rdy));
    chk({nm, ".req"},   32'(req), 32'(e_req));
    chk({nm, ".data"},  32'(wd),  32'(e_wd));
    chk({nm, ".count"}, 32'(cnt), 32'(e_cnt));
  endtask

  initial begin
    // single word, then busy-ignore with 0x555
    tbl[0]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 12'hABC, 16'd1};
    tbl[1]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'hABC, 16'd1};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'hABC, 16'd1};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'hABC, 16'd1};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'hABC, 16'd1};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'hABC, 16'd1};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'hABC, 16'd1};
    tbl[7]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'hABC, 16'd1};
    tbl[8]  = '{1'b1, 12'h123, 1'b0, 1'b1, 12'h123, 16'd2};
    tbl[9]  = '{1'b1, 12'h555, 1'b0, 1'b1, 12'h123, 16'd2};
    tbl[10] = '{1'b0, 12'h555, 1'b0, 1'b1, 12'h123, 16'd2};
    tbl[11] = '{1'b1, 12'h555, 1'b0, 1'b0, 12'h123, 16'd2};
    tbl[12] = '{1'b0, 12'h555, 1'b0, 1'b0, 12'h123, 16'd2};
    tbl[13] = '{1'b1, 12'h555, 1'b0, 1'b0, 12'h123, 16'd2};
    tbl[14] = '{1'b1, 12'h555, 1'b0, 1'b0, 12'h123, 16'd2};
    tbl[15] = '{1'b1, 12'h555, 1'b1, 1'b0, 12'h123, 16'd2};
    tbl[16] = '{1'b0, 12'h555, 1'b1, 1'b0, 12'h123, 16'd2};

    // reset state
    #1 rst = 1'b1;
    #1;
    chk_all("reset", 1'b1, 1'b0, 12'h000, 16'd0);
    chk("reset.ready2", 32'(rdy2), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // table: single word and busy ignore
    for (int i = 0; i < 17; i++) begin
      v = tbl[i].v;
      d = tbl[i].d;
      @(posedge clk);
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].rdy,
              tbl[i].req, tbl[i].wd, tbl[i].cnt);
      @(negedge clk);
    end

    // streaming, in_valid held high, words 1,2,3
    for (int k = 0; k < 24; k++) begin
      v = (k <= 16);
      d = 12'((k + 7) / 8 + 1);
      @(posedge clk);
      #1;
      chk_all($sformatf("strm%0d", k),
              (k % 8) == 7, (k % 8) < 3,
              12'(k / 8 + 1), 16'(2 + k / 8 + 1));
      @(negedge clk);
    end
    v = 1'b0;

    // reset during the second REQ cycle
    v = 1'b1;
    d = 12'h777;
    @(posedge clk);
    #1;
    chk("rst.pre_req", 32'(req), 32'd1);
    @(negedge clk);
    v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("rst.mid", 1'b1, 1'b0, 12'h000, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // single word after reset
    for (int k = 0; k < 8; k++) begin
      v = (k == 0);
      d = (k == 0) ? 12'hABC : 12'h000;
      @(posedge clk);
      #1;
      chk_all($sformatf("post%0d", k), k == 7, k < 3,
              12'hABC, 16'd1);
      @(negedge clk);
    end

    // wrap of sent_count
    force dut.sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_q;
    @(posedge clk);
    #1;
    chk("wrap.hold", 32'(cnt), 32'h0000FFFF);
    @(negedge clk);
    v = 1'b1;
    d = 12'h3C3;
    @(posedge clk);
    #1;
    chk_all("wrap", 1'b0, 1'b1, 12'h3C3, 16'h0000);
    @(negedge clk);
    v = 1'b0;
    repeat (7) @(negedge clk);
    chk("wrap.idle", 32'(rdy), 32'd1);

    // REQ_HIGH=1, GAP_CYCLES=1 streaming, period 3
    for (int k = 0; k < 12; k++) begin
      v2 = (k <= 9);
      d2 = 12'(2560 + (k + 2) / 3 + 1);
      @(posedge clk);
      #1;
      chk($sformatf("e%0d.req", k),
          32'(req2), 32'((k % 3) == 0));
      chk($sformatf("e%0d.ready", k),
          32'(rdy2), 32'((k % 3) == 2));
      chk($sformatf("e%0d.data", k),
          32'(wd2), 32'(2560 + k / 3 + 1));
      chk($sformatf("e%0d.count", k),
          32'(cnt2), 32'(k / 3 + 1));
      @(negedge clk);
    end
    v2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
